// File: rtl/ssd_scan_if.sv
// ssd_scan_if -- load/capture bus for the ssd_scan multiplexed display driver.
// The master presents a new display word and decimal-point mask together with
// a one-cycle load strobe; the slave reports busy while that value waits for
// the next frame boundary before it becomes visible.
interface ssd_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] word;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                busy;

  modport master (
    output word,
    output dp,
    output load,
    input  busy
  );

  modport slave (
    input  word,
    input  dp,
    input  load,
    output busy
  );
endinterface

// File: rtl/ssd_scan.sv
// ssd_scan -- time-multiplexed hex seven-segment display driver.
//
// A free-running slot counter gives each digit 2^SCAN_W clocks. The top four
// slot-counter bits form a PWM ramp that is compared against bright. New
// values arrive in a shadow register and move to the display register only at
// a frame boundary, so a frame never shows a mix of old and new digits.
// Leading-zero blanking, a display enable and brightness act immediately.
//
// Optional feature: define SSD_SCAN_BLINK_EN to add a per-digit blink mask
// port (blink) and a free-running BLINK_W-bit blink counter; while the counter
// MSB is set, digits whose blink bit is 1 are dark. Without the macro there is
// no blink port, no blink counter, and BLINK_W has no effect.
module ssd_scan #(
  parameter int DIGITS  = 4,
  parameter int SCAN_W  = 14,
  parameter int BLINK_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  ssd_scan_if.slave         bus,
`ifdef SSD_SCAN_BLINK_EN
  input  logic [DIGITS-1:0] blink,
`endif
  input  logic              en,
  input  logic              lzb,
  input  logic [3:0]        bright,
  output logic [DIGITS-1:0] sen,
  output logic [6:0]        seg,
  output logic              sdp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // Parameter sanity: these empty blocks name illegal configurations so they
  // stand out in an elaborated hierarchy.
  if (DIGITS < 1 || DIGITS > 8) begin : g_digits_out_of_range
  end
  if (SCAN_W < 4) begin : g_scan_w_too_small
  end
  if (BLINK_W < 1) begin : g_blink_w_too_small
  end

  // Scan state
  logic [SCAN_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  logic              slot_wrap;
  logic              frame_end;

  // Value path
  logic [4*DIGITS-1:0] shadow_word;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_word;
  logic [DIGITS-1:0]   disp_dp;
  logic                busy_q;

  // Per-cycle decode
  logic [DIGITS-1:0] zero_tail;
  logic [DIGITS-1:0] blanked;
  logic [3:0]        cur_nibble;
  logic              cur_dp;
  logic              cur_blank;
  logic [3:0]        ramp;
  logic              lit;
  logic [DIGITS-1:0] sen_next;
  logic [6:0]        seg_next;
  logic              sdp_next;

  // Hex to {A,B,C,D,E,F,G}, A in the MSB.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  assign slot_wrap = &slot_cnt;
  assign frame_end = slot_wrap && (idx == LAST_IDX);
  assign bus.busy  = busy_q;

  // Slot counter and digit index: each digit owns one full wrap of the slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow capture and frame-boundary commit; a load on the boundary cycle refills the shadow after the commit reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_word <= '0;
      shadow_dp   <= '0;
      disp_word   <= '0;
      disp_dp     <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (frame_end && busy_q) begin
        disp_word <= shadow_word;
        disp_dp   <= shadow_dp;
        busy_q    <= 1'b0;
      end
      if (bus.load) begin
        shadow_word <= bus.word;
        shadow_dp   <= bus.dp;
        busy_q      <= 1'b1;
      end
    end
  end

`ifdef SSD_SCAN_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  assign blink_phase = blink_cnt[BLINK_W-1];

  // Free-running blink timebase; its MSB selects the dark half of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`endif

  // Mark digits whose own nibble and every more significant nibble are zero.
  always_comb begin
    logic tail;
    zero_tail = '0;
    tail      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail         = tail && (disp_word[4*i +: 4] == 4'h0);
      zero_tail[i] = tail;
    end
  end

  // Per-digit blanking: leading zeros (never digit 0, never a digit with its point set) plus optional blink.
  always_comb begin
    blanked = '0;
    for (int i = 1; i < DIGITS; i++) begin
      blanked[i] = lzb && zero_tail[i] && !disp_dp[i];
    end
`ifdef SSD_SCAN_BLINK_EN
    if (blink_phase) begin
      blanked = blanked | blink;
    end
`endif
  end

  // Select the nibble, point and blank state of the digit currently being scanned.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = disp_word[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_blank  = blanked[i];
      end
    end
  end

  assign ramp = slot_cnt[SCAN_W-1 -: 4];
  assign lit  = en && ((ramp < bright) || (bright == 4'hF)) && !cur_blank;

  // Next pin values: one enable pulled low and segments driven only while the digit is lit.
  always_comb begin
    sen_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (lit && (idx == IDX_W'(i))) begin
        sen_next[i] = 1'b0;
      end
    end
    seg_next = lit ? hex_to_seg(cur_nibble) : 7'h00;
    sdp_next = lit && cur_dp;
  end

  // Output register keeps the pins glitch-free; they trail the scan state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sen <= '1;
      seg <= '0;
      sdp <= 1'b0;
    end else begin
      sen <= sen_next;
      seg <= seg_next;
      sdp <= sdp_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan -- scoreboard bench for ssd_scan (DIGITS=4, SCAN_W=4, BLINK_W=6).
// The driver computes the expected pins for each upcoming clock from a
// cycle-count model of the scan and pushes them into a queue; a separate
// monitor pops and compares on every falling edge.
module tb_ssd_scan;
  localparam int DIGITS    = 4;
  localparam int SCAN_W    = 4;
  localparam int BLINK_W   = 6;
  localparam int SLOT_LEN  = 1 << SCAN_W;
  localparam int FRAME_LEN = SLOT_LEN * DIGITS;
  localparam int BLINK_LEN = 1 << BLINK_W;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [DIGITS-1:0] sen;
    logic [6:0]        seg;
    logic              sdp;
    logic              busy;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              lzb = 1'b0;
  logic [3:0]        bright = 4'h0;
  logic [DIGITS-1:0] blink = '0;
  logic [DIGITS-1:0] sen;
  logic [6:0]        seg;
  logic              sdp;

  ssd_scan_if #(.DIGITS(DIGITS)) bus ();

  ssd_scan #(
    .DIGITS (DIGITS),
    .SCAN_W (SCAN_W),
    .BLINK_W(BLINK_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef SSD_SCAN_BLINK_EN
    .blink (blink),
`endif
    .en    (en),
    .lzb   (lzb),
    .bright(bright),
    .sen   (sen),
    .seg   (seg),
    .sdp   (sdp)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: t counts clocks since reset release.
  int unsigned       t = 0;
  logic [15:0]       m_disp = '0;
  logic [DIGITS-1:0] m_disp_dp = '0;
  logic [15:0]       m_shadow = '0;
  logic [DIGITS-1:0] m_shadow_dp = '0;
  logic              m_busy = 1'b0;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Drive one clock of stimulus, predict the pins after the next rising edge, then move to just past the falling edge.
  task automatic apply_stimulus(input logic ld, input logic [15:0] w, input logic [DIGITS-1:0] d,
                                input logic e, input logic z, input logic [3:0] b,
                                input logic [DIGITS-1:0] bl);
    exp_t              x;
    int                slot;
    int                idx;
    logic              blanked;
    logic              lit;
    logic [3:0]        nib;
    logic [DIGITS-1:0] onehot;
    bus.load = ld;
    bus.word = w;
    bus.dp   = d;
    en       = e;
    lzb      = z;
    bright   = b;
    blink    = bl;

    slot    = int'(t % SLOT_LEN);
    idx     = int'((t / SLOT_LEN) % DIGITS);
    nib     = m_disp[4*idx +: 4];
    blanked = z && (idx != 0) && ((m_disp >> (4*idx)) == 16'h0) && !m_disp_dp[idx];
`ifdef SSD_SCAN_BLINK_EN
    if (((t % BLINK_LEN) >= BLINK_LEN / 2) && bl[idx]) blanked = 1'b1;
`endif
    lit    = e && (((slot >> (SCAN_W - 4)) < int'(b)) || (b == 4'hF)) && !blanked;
    onehot = DIGITS'(1) << idx;
    x.sen  = lit ? ~onehot : '1;
    x.seg  = lit ? SEG_TAB[nib] : 7'h00;
    x.sdp  = lit && m_disp_dp[idx];

    if (((t % FRAME_LEN) == FRAME_LEN - 1) && m_busy) begin
      m_disp    = m_shadow;
      m_disp_dp = m_shadow_dp;
      m_busy    = 1'b0;
    end
    if (ld) begin
      m_shadow    = w;
      m_shadow_dp = d;
      m_busy      = 1'b1;
    end
    x.busy = m_busy;
    t++;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic run_idle(input int n, input logic e, input logic z, input logic [3:0] b,
                          input logic [DIGITS-1:0] bl);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 16'($urandom), DIGITS'($urandom), e, z, b, bl);
    end
  endtask

  task automatic run_to_frame_offset(input int off);
    while ((t % FRAME_LEN) != off) begin
      apply_stimulus(1'b0, 16'($urandom), '0, 1'b1, 1'b0, 4'hF, '0);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check_output({tag, "_sen"}, 8'(sen), 8'h0F);
    check_output({tag, "_seg"}, 8'(seg), 8'h00);
    check_output({tag, "_sdp"}, 8'(sdp), 8'h00);
    check_output({tag, "_busy"}, 8'(bus.busy), 8'h00);
  endtask

  // Assert reset between clock edges, check the pins react without a clock, then release.
  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    bus.load = 1'b0;
    #1;
    check_reset_pins({tag, "_async"});
    exp_q.delete();
    t           = 0;
    m_disp      = '0;
    m_disp_dp   = '0;
    m_shadow    = '0;
    m_shadow_dp = '0;
    m_busy      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_pins({tag, "_held"});
    rst_n = 1'b1;
  endtask

  // Monitor: compare every DUT output sample against the oldest prediction.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check_output("sen", 8'(sen), 8'(x.sen));
      check_output("seg", 8'(seg), 8'(x.seg));
      check_output("sdp", 8'(sdp), 8'(x.sdp));
      check_output("busy", 8'(bus.busy), 8'(x.busy));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] mask;
    bus.load = 1'b0;
    bus.word = '0;
    bus.dp   = '0;
    @(negedge clk);
    #1;
    do_reset("por");

    // Basic display of 1234 after the first frame boundary.
    apply_stimulus(1'b1, 16'h1234, 4'b0000, 1'b1, 1'b0, 4'hF, '0);
    run_idle(2 * FRAME_LEN, 1'b1, 1'b0, 4'hF, '0);

    // Two loads inside one frame and a third on the boundary cycle.
    run_to_frame_offset(5);
    apply_stimulus(1'b1, 16'hAAAA, 4'b0000, 1'b1, 1'b0, 4'hF, '0);
    run_idle(10, 1'b1, 1'b0, 4'hF, '0);
    apply_stimulus(1'b1, 16'h00F0, 4'b0000, 1'b1, 1'b0, 4'hF, '0);
    run_to_frame_offset(FRAME_LEN - 1);
    apply_stimulus(1'b1, 16'h5555, 4'b0000, 1'b1, 1'b0, 4'hF, '0);
    run_idle(2 * FRAME_LEN, 1'b1, 1'b0, 4'hF, '0);

    // Leading-zero blanking, then a decimal point holding the top digit lit.
    apply_stimulus(1'b1, 16'h0070, 4'b0000, 1'b1, 1'b1, 4'hF, '0);
    run_idle(2 * FRAME_LEN, 1'b1, 1'b1, 4'hF, '0);
    apply_stimulus(1'b1, 16'h0070, 4'b1000, 1'b1, 1'b1, 4'hF, '0);
    run_idle(2 * FRAME_LEN, 1'b1, 1'b1, 4'hF, '0);

    // Brightness 4, brightness 0, display disabled.
    run_idle(FRAME_LEN, 1'b1, 1'b0, 4'h4, '0);
    run_idle(FRAME_LEN, 1'b1, 1'b0, 4'h0, '0);
    run_idle(FRAME_LEN, 1'b0, 1'b0, 4'hF, '0);

    // Blink mask on digit 0 across two blink periods.
    run_idle(2 * BLINK_LEN, 1'b1, 1'b0, 4'hF, 4'b0001);

    // Reset mid-slot while a value is pending: display must come back as zero.
    apply_stimulus(1'b1, 16'h9876, 4'b0101, 1'b1, 1'b0, 4'hF, '0);
    run_idle(7, 1'b1, 1'b0, 4'hF, '0);
    do_reset("mid");
    run_idle(2 * FRAME_LEN, 1'b1, 1'b0, 4'hF, '0);

    // Randomized traffic with occasional loads and varied controls.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      apply_stimulus($urandom_range(0, 29) == 0,
                     16'($urandom) & mask,
                     ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : '0,
                     $urandom_range(0, 7) != 0,
                     1'($urandom),
                     ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom),
                     DIGITS'($urandom));
      if (i == 1500) do_reset("rnd");
    end

    @(negedge clk);
    #1;
    check_output("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter SCAN_W, default 14: digit slot length is 2^SCAN_W clocks; minimum 4.
REQ-003 Parameter BLINK_W, default 24: blink period is 2^BLINK_W clocks; used only under REQ-030.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 WORD  in  4*DIGITS  new display value; nibble i is shown on digit i.
REQ-007 DP  in  DIGITS  new decimal-point mask, captured together with WORD.
REQ-008 LOAD  in  1  one-cycle strobe that captures WORD/DP into the shadow register.
REQ-009 BUSY  out  1  high while a captured value awaits its frame-boundary commit.
REQ-010 EN  in  1  display enable; when 0, all digits off.
REQ-011 LZB  in  1  leading-zero blanking enable.
REQ-012 BRIGHT  in  4  brightness duty; 0 = off, 15 = always on.
REQ-013 SEN  out  DIGITS  digit enables, active-low, one-hot-low while lit.
REQ-014 SEG  out  7  segments {A,B,C,D,E,F,G}, A = MSB, active-high.
REQ-015 SDP  out  1  decimal-point segment, active-high.

Function
REQ-016 Slot counter: SCAN_W bits, free-running, increments every clock, wraps to 0.
REQ-017 Digit index: advances by 1 when the slot counter wraps; DIGITS-1 wraps to 0.
REQ-018 Frame boundary: the cycle in which the slot counter wraps while the index equals DIGITS-1.
REQ-019 LOAD: WORD/DP go into the shadow register and BUSY goes to 1 on the next edge. A second LOAD before commit overwrites the shadow; the last one wins.
REQ-020 Commit: at a frame boundary with BUSY=1, shadow → display register and BUSY → 0. The display therefore never changes mid-frame (no tearing).
REQ-021 LOAD in a frame-boundary cycle: the commit uses the shadow contents from before that edge. The new value enters the shadow and BUSY stays 1.
REQ-022 Lit condition for the current digit: EN=1, the top 4 slot-counter bits < BRIGHT (or BRIGHT=15), and the digit is not blanked.
REQ-023 Lit digit: its SEN bit = 0 and all other SEN bits = 1.
REQ-024 Unlit digit: all SEN bits = 1, SEG = 0, SDP = 0.
REQ-025 Leading-zero blanking (LZB=1): digit i > 0 is blanked when display nibbles i..DIGITS-1 are all 0. Digit 0 is never blanked by LZB. A digit whose DP bit is set is not blanked.
REQ-026 Segment decode, hex 0..F (A..G): 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
REQ-027 SDP = display DP bit of the current digit, gated by the lit condition.
REQ-028 SEN, SEG and SDP are registered: pins reflect the index/counter state one clock later.
REQ-029 EN, LZB and BRIGHT act immediately, with the REQ-028 latency only, and are not frame-synchronised.

Configuration
REQ-030 Macro SSD_SCAN_BLINK_EN defined: the module adds port BLINK (in, DIGITS, per-digit blink mask) and a free-running BLINK_W-bit counter. While that counter's MSB = 1, digits with BLINK=1 are blanked. The counter is reset to 0.
REQ-031 Macro not defined: there is no BLINK port and no blink counter, BLINK_W is ignored, and behaviour is exactly REQ-016..029.

Reset
REQ-032 While RST_N=0: slot counter 0, index 0, display and shadow registers 0, BUSY 0, SEN all 1, SEG 0, SDP 0, blink counter 0.
REQ-033 Reset asserted mid-frame or with BUSY=1 discards the pending value. After release, scanning restarts at digit 0 with a full slot.

Verification
REQ-034 DIGITS=4, SCAN_W=4, EN=1, BRIGHT=15, LOAD WORD=16'h1234 DP=0 → BUSY=1 until the first frame boundary. Then SEN cycles 1110/1101/1011/0111 with SEG 33/79/6D/30, each for 16 clocks.
REQ-035 Two LOADs (16'hAAAA, then 16'h00F0) inside one frame, plus a LOAD of 16'h5555 on the frame-boundary cycle → the next frame shows 00F0, BUSY stays 1, and the following frame shows 5555.
REQ-036 LZB=1, WORD=16'h0070 → digits 3 and 2 blanked (SEN bit held 1, SEG=0), digit 1 shows 70, digit 0 shows 7E. With DP=4'b1000, digit 3 shows 7E with SDP=1.
REQ-037 BRIGHT=4, SCAN_W=4 → each digit's SEN is low for the first 4 of its 16 slot clocks. BRIGHT=0 → SEN stays all-ones for a full frame.
REQ-038 RST_N pulsed low mid-slot with BUSY=1 → all outputs at reset values asynchronously, BUSY=0. The display stays 0 (digit 0 shows 7E) until a new LOAD commits.
REQ-039 SSD_SCAN_BLINK_EN defined, BLINK_W=6, BLINK=4'b0001 → digit 0 is dark during clocks 32..63 of every 64-clock blink period, and the other digits are unaffected.
